// File: rtl/proc_pkg.sv
// Shared encodings for the branch controller: opcode and FSM state types,
// plus the raw opcode decoder (unused codes fall back to NOP).
package proc_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_JMP  = 3'd1,
      OP_BRF  = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   function automatic op_e decode_op(input logic [2:0] raw);
      op_e op;
      case (raw)
         3'd1:    op = OP_JMP;
         3'd2:    op = OP_BRF;
         3'd3:    op = OP_CALL;
         3'd4:    op = OP_RET;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for CALL/RET; only built when BRANCH_CTRL_RET_STACK_EN
// is defined. Push is ignored when full, pop when empty; clear wins over both.
`ifdef BRANCH_CTRL_RET_STACK_EN
module ret_stack #(
   parameter int T     = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [T-1:0]             push_data,
   output logic [T-1:0]             top,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [T-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] top_ptr;

   assign wr_ptr  = depth[AW-1:0];
   assign top_ptr = wr_ptr - AW'(1);
   assign full    = (depth == FULL_CNT);
   assign empty   = (depth == '0);
   assign top     = mem[top_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         depth <= '0;
      end else if (push && !full) begin
         mem[wr_ptr] <= push_data;
         depth       <= depth + 1'b1;
      end else if (pop && !empty) begin
         depth <= depth - 1'b1;
      end
   end

endmodule
`endif

// File: rtl/branch_ctrl.sv
// Branch controller: decodes JMP/BRF/CALL/RET into zero-latency fetch requests
// from a target LUT. Return stack and FAULT exist only with BRANCH_CTRL_RET_STACK_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | held while Start is high; no requests, stack cleared
// ST_RUN   | decoding valid ops into branch requests
// ST_FAULT | return-stack overflow/underflow seen; waits for Start/Reset
module branch_ctrl
   import proc_pkg::*;
#(
   parameter int T     = 10,
   parameter int DEPTH = 4,
   parameter int LUTW  = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic [T-1:0]             ProgCtr,
   input  logic                     OpValid,
   input  logic [2:0]               Op,
   input  logic [LUTW-1:0]          LutIdx,
   input  logic                     ALU_flag,
   input  logic                     LutWe,
   input  logic [LUTW-1:0]          LutWAddr,
   input  logic [T-1:0]             LutWData,
   output logic                     BranchAbs,
   output logic                     BranchRelEn,
   output logic [T-1:0]             Target,
   output logic [$clog2(DEPTH):0]   StackDepth,
   output logic                     Fault
);
   localparam int LUTN = 2**LUTW;

   state_e       state;
   state_e       state_nxt;
   op_e          op;
   logic [T-1:0] lut [LUTN];
   logic [T-1:0] lut_rd;
   logic         push;
   logic         pop;
   logic         unused_ok;

   assign op     = decode_op(Op);
   assign lut_rd = lut[LutIdx];

   // Registered LUT: a read in the write cycle still sees the old entry.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < LUTN; i++) lut[i] <= '0;
      end else if (LutWe) begin
         lut[LutWAddr] <= LutWData;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

`ifdef BRANCH_CTRL_RET_STACK_EN
   logic [T-1:0] stk_top;
   logic         stk_full;
   logic         stk_empty;

   ret_stack #(.T(T), .DEPTH(DEPTH)) u_ret_stack (
      .clk       (Clk),
      .rst_n     (Reset),
      .clear     (Start),
      .push      (push),
      .pop       (pop),
      .push_data (ProgCtr + T'(1)),
      .top       (stk_top),
      .depth     (StackDepth),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   assign Fault     = (state == ST_FAULT);
   // The fetch stage resolves the BRF condition itself.
   assign unused_ok = ALU_flag;
`else
   assign StackDepth = '0;
   assign Fault      = 1'b0;
   assign unused_ok  = ^{ALU_flag, ProgCtr, push, pop};
`endif

   always_comb begin
      state_nxt   = state;
      BranchAbs   = 1'b0;
      BranchRelEn = 1'b0;
      Target      = '0;
      push        = 1'b0;
      pop         = 1'b0;
      case (state)
         ST_IDLE: state_nxt = ST_RUN;
         ST_RUN: begin
            if (OpValid) begin
               case (op)
                  OP_JMP: begin
                     BranchAbs = 1'b1;
                     Target    = lut_rd;
                  end
                  OP_BRF: begin
                     BranchRelEn = 1'b1;
                     Target      = lut_rd;
                  end
`ifdef BRANCH_CTRL_RET_STACK_EN
                  OP_CALL: begin
                     if (stk_full) begin
                        state_nxt = ST_FAULT;
                     end else begin
                        BranchAbs = 1'b1;
                        Target    = lut_rd;
                        push      = 1'b1;
                     end
                  end
                  OP_RET: begin
                     if (stk_empty) begin
                        state_nxt = ST_FAULT;
                     end else begin
                        BranchAbs = 1'b1;
                        Target    = stk_top;
                        pop       = 1'b1;
                     end
                  end
`else
                  OP_CALL: begin
                     BranchAbs = 1'b1;
                     Target    = lut_rd;
                  end
`endif
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
      if (Start) state_nxt = ST_IDLE;
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; expectations go through a scoreboard queue.
// Covers both builds, selected by BRANCH_CTRL_RET_STACK_EN.
module tb_branch_ctrl;
   localparam int T     = 10;
   localparam int DEPTH = 4;
   localparam int LUTW  = 4;
   localparam int DW    = $clog2(DEPTH) + 1;

   localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, BRF = 3'd2, CALL = 3'd3, RET = 3'd4;
`ifdef BRANCH_CTRL_RET_STACK_EN
   localparam logic STK = 1'b1;
`else
   localparam logic STK = 1'b0;
`endif

   logic            Clk = 1'b0;
   logic            Reset, Start, OpValid, ALU_flag, LutWe;
   logic [T-1:0]    ProgCtr, LutWData, Target;
   logic [2:0]      Op;
   logic [LUTW-1:0] LutIdx, LutWAddr;
   logic            BranchAbs, BranchRelEn, Fault;
   logic [DW-1:0]   StackDepth;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string         tag;
      logic          abs;
      logic          rel;
      logic [T-1:0]  tgt;
      logic [DW-1:0] dep;
      logic          flt;
   } exp_t;
   exp_t sb[$];

   branch_ctrl #(.T(T), .DEPTH(DEPTH), .LUTW(LUTW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr),
      .OpValid(OpValid), .Op(Op), .LutIdx(LutIdx), .ALU_flag(ALU_flag),
      .LutWe(LutWe), .LutWAddr(LutWAddr), .LutWData(LutWData),
      .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn), .Target(Target),
      .StackDepth(StackDepth), .Fault(Fault)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_push(input string tag, input logic e_abs, input logic e_rel,
                              input logic [T-1:0] e_tgt, input logic [DW-1:0] e_dep, input logic e_flt);
      sb.push_back('{tag, e_abs, e_rel, e_tgt, e_dep, e_flt});
   endtask

   task automatic check_pop();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".abs"},   BranchAbs,   e.abs);
         chk({e.tag, ".rel"},   BranchRelEn, e.rel);
         chk({e.tag, ".tgt"},   Target,      e.tgt);
         chk({e.tag, ".depth"}, StackDepth,  e.dep);
         chk({e.tag, ".fault"}, Fault,       e.flt);
      end
   endtask

   // Drive one cycle just after the edge, compare on the following falling edge.
   task automatic step(input string tag, input logic st, input logic v, input logic [2:0] op,
                       input logic [LUTW-1:0] idx, input logic fl, input logic [T-1:0] pc,
                       input logic we, input logic [LUTW-1:0] wa, input logic [T-1:0] wd,
                       input logic e_abs, input logic e_rel, input logic [T-1:0] e_tgt,
                       input logic [DW-1:0] e_dep, input logic e_flt);
      @(posedge Clk);
      #1;
      Start = st; OpValid = v; Op = op; LutIdx = idx; ALU_flag = fl; ProgCtr = pc;
      LutWe = we; LutWAddr = wa; LutWData = wd;
      expect_push(tag, e_abs, e_rel, e_tgt, e_dep, e_flt);
      @(negedge Clk);
      check_pop();
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [LUTW-1:0] idx,
                      input logic fl, input logic [T-1:0] pc,
                      input logic e_abs, input logic e_rel, input logic [T-1:0] e_tgt,
                      input logic [DW-1:0] e_dep, input logic e_flt);
      step(tag, 1'b0, 1'b1, op, idx, fl, pc, 1'b0, '0, '0, e_abs, e_rel, e_tgt, e_dep, e_flt);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed no finish expected finish before 50000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b0; Start = 1'b0; OpValid = 1'b1; Op = JMP; LutIdx = 4'd3; ALU_flag = 1'b0;
      ProgCtr = '0; LutWe = 1'b0; LutWAddr = '0; LutWData = '0;
      #2;
      expect_push("reset", 1'b0, 1'b0, '0, '0, 1'b0);
      check_pop();
      @(negedge Clk);
      Reset = 1'b1; Start = 1'b1; OpValid = 1'b0;

      // IDLE under Start: fill the LUT, requests suppressed
      step("idle_w3", 1, 0, NOP, 0, 0, 0, 1, 4'd3, 10'h120, 0, 0, 10'h000, 0, 0);
      step("idle_w1", 1, 1, JMP, 3, 0, 0, 1, 4'd1, 10'h3FE, 0, 0, 10'h000, 0, 0);
      step("idle_w5", 1, 0, NOP, 0, 0, 0, 1, 4'd5, 10'h2A5, 0, 0, 10'h000, 0, 0);
      step("idle_w7", 1, 0, NOP, 0, 0, 0, 1, 4'd7, 10'h0AA, 0, 0, 10'h000, 0, 0);
      step("idle_rel", 0, 1, JMP, 3, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 0, 0);

      run("jmp3",      JMP,  4'd3, 0, 10'h000, 1, 0, 10'h120, 0, 0);
      step("novalid", 0, 0, JMP, 3, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 0, 0);
      run("nop",       NOP,  4'd3, 0, 10'h000, 0, 0, 10'h000, 0, 0);
      run("op7",       3'd7, 4'd3, 0, 10'h000, 0, 0, 10'h000, 0, 0);
      run("brf_t",     BRF,  4'd1, 1, 10'h000, 0, 1, 10'h3FE, 0, 0);
      run("brf_f",     BRF,  4'd1, 0, 10'h000, 0, 1, 10'h3FE, 0, 0);
      step("wr_rd_old", 0, 1, JMP, 5, 0, 0, 1, 4'd5, 10'h155, 1, 0, 10'h2A5, 0, 0);
      run("rd_new",    JMP,  4'd5, 0, 10'h000, 1, 0, 10'h155, 0, 0);
      run("lut_rst9",  JMP,  4'd9, 0, 10'h000, 1, 0, 10'h000, 0, 0);

      run("call40",    CALL, 4'd7, 0, 10'h040, 1, 0, 10'h0AA, 0, 0);
      run("ret41",     RET,  4'd0, 0, 10'h000, STK, 0, STK ? 10'h041 : 10'h000, DW'(STK), 0);
      run("post_ret",  NOP,  4'd0, 0, 10'h000, 0, 0, 10'h000, 0, 0);

`ifdef BRANCH_CTRL_RET_STACK_EN
      run("call_1",    CALL, 4'd7, 0, 10'h100, 1, 0, 10'h0AA, 3'd0, 0);
      run("call_2",    CALL, 4'd7, 0, 10'h101, 1, 0, 10'h0AA, 3'd1, 0);
      run("call_3",    CALL, 4'd7, 0, 10'h102, 1, 0, 10'h0AA, 3'd2, 0);
      run("call_4",    CALL, 4'd7, 0, 10'h103, 1, 0, 10'h0AA, 3'd3, 0);
      run("call_ovf",  CALL, 4'd7, 0, 10'h104, 0, 0, 10'h000, 3'd4, 0);
      run("fault_ovf", JMP,  4'd3, 0, 10'h000, 0, 0, 10'h000, 3'd4, 1);
      step("ovf_start", 1, 1, JMP, 3, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 3'd4, 1);
      step("ovf_idle", 0, 0, NOP, 0, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 3'd0, 0);
      run("ret_udf",   RET,  4'd0, 0, 10'h000, 0, 0, 10'h000, 3'd0, 0);
      run("fault_udf", NOP,  4'd0, 0, 10'h000, 0, 0, 10'h000, 3'd0, 1);
      step("udf_start", 1, 0, NOP, 0, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 3'd0, 1);
      step("udf_idle", 0, 0, NOP, 0, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 3'd0, 0);
`endif

      step("start_pulse", 1, 0, NOP, 0, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 0, 0);
      step("restart_idle", 0, 1, JMP, 3, 0, 0, 0, 4'd0, 10'h000, 0, 0, 10'h000, 0, 0);
      run("restart_jmp", JMP, 4'd3, 0, 10'h000, 1, 0, 10'h120, 0, 0);

      run("call_3ff",  CALL, 4'd7, 0, 10'h3FF, 1, 0, 10'h0AA, 0, 0);
      run("ret_wrap",  RET,  4'd0, 0, 10'h000, STK, 0, 10'h000, DW'(STK), 0);
      run("call_50",   CALL, 4'd7, 0, 10'h050, 1, 0, 10'h0AA, 0, 0);

      // Reset asserted in the middle of a CALL cycle
      @(posedge Clk);
      #1;
      Start = 1'b0; OpValid = 1'b1; Op = CALL; LutIdx = 4'd7; ProgCtr = 10'h060;
      expect_push("midcall", 1'b1, 1'b0, 10'h0AA, DW'(STK), 1'b0);
      #1;
      check_pop();
      Reset = 1'b0;
      #1;
      expect_push("rst_async", 1'b0, 1'b0, '0, '0, 1'b0);
      check_pop();
      @(posedge Clk);
      #1;
      expect_push("rst_hold", 1'b0, 1'b0, '0, '0, 1'b0);
      check_pop();
      @(negedge Clk);
      Reset = 1'b1; OpValid = 1'b0;

      run("post_rst3", JMP, 4'd3, 0, 10'h000, 1, 0, 10'h000, 0, 0);
      run("post_rst7", JMP, 4'd7, 0, 10'h000, 1, 0, 10'h000, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter T, default 10: program-counter and target width.
REQ-002 SHALL have parameter DEPTH, default 4: return-stack entries, power of two, 2..16.
REQ-003 SHALL have parameter LUTW, default 4: target-LUT index width, 2**LUTW entries.
REQ-004 SHALL have port Clk  in  1: single clock, all state on posedge.
REQ-005 SHALL have port Reset  in  1: asynchronous, active-low (0 = reset).
REQ-006 SHALL have port Start  in  1: hold the block in IDLE while high.
REQ-007 SHALL have port ProgCtr  in  T: current program counter of the fetch stage.
REQ-008 SHALL have port OpValid  in  1: Op is valid this cycle.
REQ-009 SHALL have port Op  in  3: NOP=0, JMP=1, BRF=2 (relative, conditional), CALL=3, RET=4; others decode as NOP.
REQ-010 SHALL have port LutIdx  in  LUTW: target-LUT index for JMP, BRF and CALL.
REQ-011 SHALL have port ALU_flag  in  1: branch condition for BRF.
REQ-012 SHALL have port LutWe  in  1: LUT write enable.
REQ-013 SHALL have port LutWAddr  in  LUTW: LUT write address.
REQ-014 SHALL have port LutWData  in  T: LUT write data.
REQ-015 SHALL have port BranchAbs  out  1: absolute jump request to the fetch stage.
REQ-016 SHALL have port BranchRelEn  out  1: relative branch enable to the fetch stage.
REQ-017 SHALL have port Target  out  T: jump target or relative offset.
REQ-018 SHALL have port StackDepth  out  $clog2(DEPTH)+1: occupied return-stack entries.
REQ-019 SHALL have port Fault  out  1: sticky return-stack overflow/underflow indicator.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, FAULT; IDLE->RUN on the first edge with Start low; any state->IDLE on an edge with Start high; RUN->FAULT on overflow or underflow.
REQ-021 SHALL drive BranchAbs, BranchRelEn and Target combinationally from Op and state; zero latency, so fetch samples them on the same edge.
REQ-022 SHALL, in RUN with OpValid: JMP -> BranchAbs=1, Target=LUT[LutIdx]; BRF -> BranchRelEn=1, Target=LUT[LutIdx] (2's-complement offset, modulo 2**T); CALL -> BranchAbs=1, Target=LUT[LutIdx], push ProgCtr+1 (modulo 2**T); RET -> BranchAbs=1, Target=top of stack, pop.
REQ-023 SHALL drive BranchAbs=0, BranchRelEn=0, Target=0 in IDLE, in FAULT, when OpValid=0, or for NOP.
REQ-024 SHALL treat CALL at StackDepth==DEPTH as overflow: no push, no branch, enter FAULT next edge.
REQ-025 SHALL treat RET at StackDepth==0 as underflow: no pop, no branch, enter FAULT next edge.
REQ-026 SHALL hold Fault=1 in FAULT until Reset or Start.
REQ-027 SHALL perform LUT writes on posedge in any state; a same-cycle read of the written index returns the old value.
REQ-028 SHALL clear the stack (StackDepth=0) on entry to IDLE; LUT contents are retained.

Reset
REQ-029 SHALL, on Reset low, set state=IDLE, StackDepth=0, Fault=0, and all LUT and stack entries to 0.
REQ-030 SHALL abandon any in-flight push/pop when Reset asserts mid-operation, with no partial update.

Configuration
REQ-031 SHALL compile the return stack only when BRANCH_CTRL_RET_STACK_EN is defined.
REQ-032 SHALL, without BRANCH_CTRL_RET_STACK_EN: CALL behaves as JMP, RET as NOP, StackDepth=0, Fault=0, and FAULT is unreachable.

Structure
REQ-033 SHALL place the Op encoding enum and the FSM state typedef in shared package proc_pkg.
REQ-034 SHALL implement the return stack as sub-module ret_stack (push, pop, top, depth, full, empty).

Verification
REQ-035 SHALL test: LUT[3]=0x120 written, JMP LutIdx=3 -> BranchAbs=1, Target=0x120 same cycle.
REQ-036 SHALL test: LUT[1]=0x3FE, BRF with ALU_flag=1 -> BranchRelEn=1, Target=0x3FE; with ALU_flag=0 -> BranchRelEn=1, and fetch does not branch.
REQ-037 SHALL test: CALL at ProgCtr=0x040 then RET -> RET Target=0x041, StackDepth 1 -> 0.
REQ-038 SHALL test: 5 CALLs with DEPTH=4 -> 5th CALL gives no branch, Fault=1 next cycle, StackDepth=4.
REQ-039 SHALL test: RET at StackDepth=0 -> no branch, Fault=1; Start pulse -> IDLE, Fault=0, StackDepth=0.
REQ-040 SHALL test: Reset low mid-CALL -> StackDepth=0, all outputs 0 asynchronously.
